// File: rtl/ctrl_defs.sv
// Shared constants and types for the multi-cycle control sequencer and the ALU.
package ctrl_defs;

   localparam int unsigned OP_SIZE = 4;
   localparam int unsigned STATE_W = 4;

   // Opcodes; the ALU-class opcodes double as ALU function select codes.
   localparam logic [OP_SIZE-1:0] OP_NOP  = 4'b0000;
   localparam logic [OP_SIZE-1:0] OP_LW   = 4'b0001;
   localparam logic [OP_SIZE-1:0] OP_LB   = 4'b0010;
   localparam logic [OP_SIZE-1:0] OP_SW   = 4'b0011;
   localparam logic [OP_SIZE-1:0] OP_SB   = 4'b0100;
   localparam logic [OP_SIZE-1:0] OP_AND  = 4'b0101;
   localparam logic [OP_SIZE-1:0] OP_OR   = 4'b0110;
   localparam logic [OP_SIZE-1:0] OP_ADD  = 4'b0111;
   localparam logic [OP_SIZE-1:0] OP_SUB  = 4'b1000;
   localparam logic [OP_SIZE-1:0] OP_SLT  = 4'b1001;
   localparam logic [OP_SIZE-1:0] OP_BEQ  = 4'b1010;
   localparam logic [OP_SIZE-1:0] OP_JUMP = 4'b1011;
   localparam logic [OP_SIZE-1:0] OP_ADDI = 4'b1100;

   // ALU operand B mux codes.
   localparam logic [1:0] SRC_B_REG = 2'b00;
   localparam logic [1:0] SRC_B_ONE = 2'b01;
   localparam logic [1:0] SRC_B_IMM = 2'b10;
   localparam logic [1:0] SRC_B_OFF = 2'b11;

   // PC source mux codes.
   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   // Binary state encoding; codes 13-15 are unreachable.
   localparam logic [STATE_W-1:0] S_FETCH  = 4'd0;
   localparam logic [STATE_W-1:0] S_DECODE = 4'd1;
   localparam logic [STATE_W-1:0] S_EXEC_R = 4'd2;
   localparam logic [STATE_W-1:0] S_WB_R   = 4'd3;
   localparam logic [STATE_W-1:0] S_EXEC_I = 4'd4;
   localparam logic [STATE_W-1:0] S_WB_I   = 4'd5;
   localparam logic [STATE_W-1:0] S_ADDR   = 4'd6;
   localparam logic [STATE_W-1:0] S_MEM_RD = 4'd7;
   localparam logic [STATE_W-1:0] S_WB_MEM = 4'd8;
   localparam logic [STATE_W-1:0] S_MEM_WR = 4'd9;
   localparam logic [STATE_W-1:0] S_BRANCH = 4'd10;
   localparam logic [STATE_W-1:0] S_JMP    = 4'd11;
   localparam logic [STATE_W-1:0] S_TRAP   = 4'd12;

   // Instruction class produced by the opcode decoder.
   typedef struct packed {
      logic nop;
      logic mem;
      logic load;
      logic byte_acc;
      logic rtype;
      logic imm;
      logic branch;
      logic jump;
      logic illegal;
   } op_class_t;

   // Control bundle driven onto the datapath.
   typedef struct packed {
      logic [OP_SIZE-1:0] alu_sel;
      logic               alu_src_a;
      logic [1:0]         alu_src_b;
      logic               mem_read;
      logic               mem_write;
      logic               mem_byte;
      logic               iord;
      logic               ir_write;
      logic               pc_write;
      logic [1:0]         pc_src;
      logic               reg_write;
      logic               reg_dst;
      logic               mem_to_reg;
      logic               instr_done;
   } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode to instruction-class decode.
module mc_ctrl_decode
   import ctrl_defs::*;
(
   input  logic [OP_SIZE-1:0] opcode,
   output op_class_t          cls
);

   // Classify opcode; anything unassigned is illegal.
   always_comb begin
      cls = '0;
      case (opcode)
         OP_NOP:  cls.nop = 1'b1;
         OP_LW:   begin cls.mem = 1'b1; cls.load = 1'b1; end
         OP_LB:   begin cls.mem = 1'b1; cls.load = 1'b1; cls.byte_acc = 1'b1; end
         OP_SW:   cls.mem = 1'b1;
         OP_SB:   begin cls.mem = 1'b1; cls.byte_acc = 1'b1; end
         OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: cls.rtype = 1'b1;
         OP_ADDI: cls.imm = 1'b1;
         OP_BEQ:  cls.branch = 1'b1;
         OP_JUMP: cls.jump = 1'b1;
         default: cls.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer for the 16-bit CPU datapath.
module mc_ctrl
   import ctrl_defs::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [OP_SIZE-1:0] opcode,
   input  logic               alu_zero_flag,
   input  logic               mem_ready,
   output logic [OP_SIZE-1:0] alu_sel,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic               mem_read,
   output logic               mem_write,
   output logic               mem_byte,
   output logic               iord,
   output logic               ir_write,
   output logic               pc_write,
   output logic [1:0]         pc_src,
   output logic               reg_write,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               instr_done,
   output logic               illegal
);

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] next_state;
   op_class_t          cls;
   ctrl_t              ctl;

   mc_ctrl_decode u_decode (
      .opcode (opcode),
      .cls    (cls)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_FETCH;
      else     state <= next_state;
   end

   // Sticky illegal flag, raised as the FSM enters TRAP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      illegal <= 1'b0;
      else if (next_state == S_TRAP) illegal <= 1'b1;
   end

   // Next-state and control decode; reset forces the idle bundle combinationally.
   always_comb begin
      next_state  = state;
      ctl         = '0;
      ctl.alu_sel = OP_ADD;
      case (state)
         S_FETCH: begin
            ctl.mem_read  = 1'b1;
            ctl.alu_src_b = SRC_B_ONE;
            if (mem_ready) begin
               ctl.ir_write = 1'b1;
               ctl.pc_write = 1'b1;
               ctl.pc_src   = PC_SRC_ALU;
               next_state   = S_DECODE;
            end
         end
         S_DECODE: begin
            ctl.alu_src_b = SRC_B_OFF;
            if (cls.nop) begin
               ctl.instr_done = 1'b1;
               next_state     = S_FETCH;
            end
            else if (cls.mem)    next_state = S_ADDR;
            else if (cls.rtype)  next_state = S_EXEC_R;
            else if (cls.imm)    next_state = S_EXEC_I;
            else if (cls.branch) next_state = S_BRANCH;
            else if (cls.jump)   next_state = S_JMP;
            else                 next_state = S_TRAP;
         end
         S_EXEC_R: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRC_B_REG;
            ctl.alu_sel   = opcode;
            next_state    = S_WB_R;
         end
         S_WB_R: begin
            ctl.reg_write  = 1'b1;
            ctl.reg_dst    = 1'b1;
            ctl.instr_done = 1'b1;
            next_state     = S_FETCH;
         end
         S_EXEC_I: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRC_B_IMM;
            next_state    = S_WB_I;
         end
         S_WB_I: begin
            ctl.reg_write  = 1'b1;
            ctl.instr_done = 1'b1;
            next_state     = S_FETCH;
         end
         S_ADDR: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRC_B_IMM;
            next_state    = cls.load ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            ctl.mem_read = 1'b1;
            ctl.iord     = 1'b1;
            ctl.mem_byte = cls.byte_acc;
            if (mem_ready) next_state = S_WB_MEM;
         end
         S_WB_MEM: begin
            ctl.reg_write  = 1'b1;
            ctl.mem_to_reg = 1'b1;
            ctl.instr_done = 1'b1;
            next_state     = S_FETCH;
         end
         S_MEM_WR: begin
            ctl.mem_write = 1'b1;
            ctl.iord      = 1'b1;
            ctl.mem_byte  = cls.byte_acc;
            if (mem_ready) begin
               ctl.instr_done = 1'b1;
               next_state     = S_FETCH;
            end
         end
         S_BRANCH: begin
            ctl.alu_src_a  = 1'b1;
            ctl.alu_src_b  = SRC_B_REG;
            ctl.alu_sel    = OP_SUB;
            ctl.pc_write   = alu_zero_flag;
            ctl.pc_src     = PC_SRC_ALUOUT;
            ctl.instr_done = 1'b1;
            next_state     = S_FETCH;
         end
         S_JMP: begin
            ctl.pc_write   = 1'b1;
            ctl.pc_src     = PC_SRC_JUMP;
            ctl.instr_done = 1'b1;
            next_state     = S_FETCH;
         end
         S_TRAP:  next_state = S_TRAP;
         default: next_state = S_TRAP;
      endcase
      if (rst) begin
         ctl         = '0;
         ctl.alu_sel = OP_ADD;
      end
   end

   assign alu_sel    = ctl.alu_sel;
   assign alu_src_a  = ctl.alu_src_a;
   assign alu_src_b  = ctl.alu_src_b;
   assign mem_read   = ctl.mem_read;
   assign mem_write  = ctl.mem_write;
   assign mem_byte   = ctl.mem_byte;
   assign iord       = ctl.iord;
   assign ir_write   = ctl.ir_write;
   assign pc_write   = ctl.pc_write;
   assign pc_src     = ctl.pc_src;
   assign reg_write  = ctl.reg_write;
   assign reg_dst    = ctl.reg_dst;
   assign mem_to_reg = ctl.mem_to_reg;
   assign instr_done = ctl.instr_done;

endmodule
